// File: rtl/startup_sequencer.sv
// Power-up sequencer: walks NPREREQ ordered readiness inputs, then waits on the remote FPGA.
// Define STARTUP_SEQUENCER_DEBUG_EN to expose state name, prescaler and index debug ports.
module startup_sequencer #(
    parameter int unsigned NPREREQ        = 2,
    parameter int unsigned TICKS_PER_MSEC = 40078,
    parameter int unsigned DLY_W          = 16
) (
    input  logic                           clock,
    input  logic                           global_reset_n,
    input  logic [NPREREQ-1:0]             prereq,
    input  logic [DLY_W-1:0]               cfg_delay,
    input  logic                           cfg_mode,
    input  logic                           cfg_done_in,
    input  logic                           restart,
    output logic                           msec_pulse,
    output logic [NPREREQ-1:0]             wait_stage,
    output logic                           wait_cfg,
    output logic                           startup_done,
    output logic                           startup_fail,
    output logic [DLY_W-1:0]               elapsed_msec
`ifdef STARTUP_SEQUENCER_DEBUG_EN
    ,
    output logic [31:0]                    sm_dsp,
    output logic [DLY_W-1:0]               presc_dbg,
    output logic [$clog2(NPREREQ+1)-1:0]   idx_dbg
`endif
);

    localparam int unsigned IDX_W = $clog2(NPREREQ + 1);

    localparam logic [DLY_W-1:0] PRESC_LAST = DLY_W'(TICKS_PER_MSEC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NPREREQ - 1);

    localparam logic [1:0] ST_WAIT_PRE = 2'd0;
    localparam logic [1:0] ST_WAIT_CFG = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;
    localparam logic [1:0] ST_FAIL     = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               w_idx_inc;
    logic               w_idx_clr;
    logic               w_enter_cfg;

    logic [NPREREQ-1:0] r_prereq_ff;
    logic               r_done_s1;
    logic               r_done_s2;

    logic [DLY_W-1:0]   r_dly;
    logic               r_mode;
    logic [DLY_W-1:0]   r_presc;
    logic [DLY_W-1:0]   r_elapsed;
    logic [DLY_W-1:0]   w_elapsed_next;
    logic               w_msec;
    logic               w_elapsed_sat;
    logic               w_timeout;

    logic [NPREREQ-1:0] w_stage_onehot;
    logic               w_cur_ready;

    logic [NPREREQ-1:0] r_wait_stage;
    logic               r_wait_cfg;
    logic               r_done;
    logic               r_fail;

    // Index past the last prerequisite shifts out to an all-zero stage vector.
    assign w_stage_onehot = NPREREQ'(1) << r_idx;
    assign w_cur_ready    = |(r_prereq_ff & w_stage_onehot);

    assign w_msec         = (r_state == ST_WAIT_CFG) && (r_presc == PRESC_LAST);
    assign w_elapsed_sat  = (r_elapsed == {DLY_W{1'b1}});
    assign w_elapsed_next = (w_msec && !w_elapsed_sat) ? r_elapsed + DLY_W'(1) : r_elapsed;
    assign w_timeout      = (w_elapsed_next >= r_dly);

    // Input capture: one flop for prerequisites, two-flop synchroniser for remote done.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_prereq_ff <= '0;
            r_done_s1   <= 1'b0;
            r_done_s2   <= 1'b0;
        end else begin
            r_prereq_ff <= prereq;
            r_done_s1   <= cfg_done_in;
            r_done_s2   <= r_done_s1;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state <= ST_WAIT_PRE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_state_next = r_state;
        w_idx_inc    = 1'b0;
        w_idx_clr    = 1'b0;
        w_enter_cfg  = 1'b0;
        case (r_state)
            ST_WAIT_PRE: begin
                if (w_cur_ready) begin
                    w_idx_inc = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_next = ST_WAIT_CFG;
                        w_enter_cfg  = 1'b1;
                    end
                end
            end
            ST_WAIT_CFG: begin
                if (!r_mode) begin
                    if (w_timeout) begin
                        w_state_next = ST_DONE;
                    end
                end else if (r_done_s2) begin
                    w_state_next = ST_DONE;
                end else if ((r_dly != '0) && w_timeout) begin
                    w_state_next = ST_FAIL;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (restart) begin
                    w_state_next = ST_WAIT_CFG;
                    w_enter_cfg  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_WAIT_PRE;
                w_idx_clr    = 1'b1;
            end
        endcase
    end

    // Prerequisite index; only advances, so passed inputs are never revisited.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_idx <= '0;
        end else if (w_idx_clr) begin
            r_idx <= '0;
        end else if (w_idx_inc) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Remote-wait settings latch and msec prescaler / elapsed counter.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_dly     <= '0;
            r_mode    <= 1'b0;
            r_presc   <= '0;
            r_elapsed <= '0;
        end else if (w_enter_cfg) begin
            r_dly     <= cfg_delay;
            r_mode    <= cfg_mode;
            r_presc   <= '0;
            r_elapsed <= '0;
        end else if (r_state == ST_WAIT_CFG) begin
            r_presc   <= w_msec ? '0 : r_presc + DLY_W'(1);
            r_elapsed <= w_elapsed_next;
        end
    end

    // Status outputs follow the state one clock later.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_wait_stage <= NPREREQ'(1);
            r_wait_cfg   <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_wait_stage <= (r_state == ST_WAIT_PRE) ? w_stage_onehot : '0;
            r_wait_cfg   <= (r_state == ST_WAIT_CFG);
            r_done       <= (r_state == ST_DONE);
            r_fail       <= (r_state == ST_FAIL);
        end
    end

    assign msec_pulse   = w_msec;
    assign wait_stage   = r_wait_stage;
    assign wait_cfg     = r_wait_cfg;
    assign startup_done = r_done;
    assign startup_fail = r_fail;
    assign elapsed_msec = r_elapsed;

`ifdef STARTUP_SEQUENCER_DEBUG_EN
    logic [31:0] w_sm_dsp;

    // ASCII state name for status display.
    always_comb begin
        w_sm_dsp = "????";
        case (r_state)
            ST_WAIT_PRE: w_sm_dsp = "wpre";
            ST_WAIT_CFG: w_sm_dsp = "wcfg";
            ST_DONE:     w_sm_dsp = "done";
            ST_FAIL:     w_sm_dsp = "fail";
            default:     w_sm_dsp = "????";
        endcase
    end

    assign sm_dsp    = w_sm_dsp;
    assign presc_dbg = r_presc;
    assign idx_dbg   = r_idx;
`endif

endmodule

// File: tb/tb_startup_sequencer.sv
// Bench for startup_sequencer: directed tables and sequences plus random stimulus vs a time-based model.
module tb_startup_sequencer;

    localparam int unsigned NPRE = 2;
    localparam int unsigned TPM  = 5;
    localparam int unsigned DW   = 16;

    logic            clock = 1'b0;
    logic            global_reset_n;
    logic [NPRE-1:0] prereq;
    logic [DW-1:0]   cfg_delay;
    logic            cfg_mode;
    logic            cfg_done_in;
    logic            restart;
    logic            msec_pulse;
    logic [NPRE-1:0] wait_stage;
    logic            wait_cfg;
    logic            startup_done;
    logic            startup_fail;
    logic [DW-1:0]   elapsed_msec;
`ifdef STARTUP_SEQUENCER_DEBUG_EN
    logic [31:0]     sm_dsp;
    logic [DW-1:0]   presc_dbg;
    logic [$clog2(NPRE+1)-1:0] idx_dbg;
`endif

    startup_sequencer #(.NPREREQ(NPRE), .TICKS_PER_MSEC(TPM), .DLY_W(DW)) dut (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .prereq         (prereq),
        .cfg_delay      (cfg_delay),
        .cfg_mode       (cfg_mode),
        .cfg_done_in    (cfg_done_in),
        .restart        (restart),
        .msec_pulse     (msec_pulse),
        .wait_stage     (wait_stage),
        .wait_cfg       (wait_cfg),
        .startup_done   (startup_done),
        .startup_fail   (startup_fail),
        .elapsed_msec   (elapsed_msec)
`ifdef STARTUP_SEQUENCER_DEBUG_EN
        ,
        .sm_dsp         (sm_dsp),
        .presc_dbg      (presc_dbg),
        .idx_dbg        (idx_dbg)
`endif
    );

    always #5 clock = ~clock;

    int n_checks;
    int n_pass;

    // Reference model: phase 0=prereqs, 1=remote wait, 2=done, 3=fail.
    int        m_phase;
    int        m_passed;
    int        m_t;
    int        m_el;
    int        m_dly;
    bit        m_mode;
    bit        m_d1;
    bit        m_d2;
    logic [1:0] m_pre_ff;
    logic [1:0] e_stage;
    bit        e_cfg;
    bit        e_done;
    bit        e_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_passed = 0;
        m_t      = 0;
        m_el     = 0;
        m_dly    = 0;
        m_mode   = 0;
        m_d1     = 0;
        m_d2     = 0;
        m_pre_ff = '0;
        e_stage  = 2'b01;
        e_cfg    = 0;
        e_done   = 0;
        e_fail   = 0;
    endtask

    // One clock edge of the reference behaviour, using inputs present at that edge.
    task automatic model_edge();
        int  old_phase;
        int  old_passed;
        int  el_after;
        bit  enter;
        old_phase  = m_phase;
        old_passed = m_passed;
        enter      = 0;
        case (old_phase)
            0: if (m_pre_ff[m_passed]) begin
                m_passed++;
                if (m_passed == NPRE) begin
                    m_phase = 1;
                    enter   = 1;
                end
            end
            1: begin
                el_after = (m_t + 1) / TPM;
                if (el_after > 65535) el_after = 65535;
                m_el = el_after;
                m_t++;
                if (!m_mode) begin
                    if (el_after >= m_dly) m_phase = 2;
                end else if (m_d2) begin
                    m_phase = 2;
                end else if (m_dly != 0 && el_after >= m_dly) begin
                    m_phase = 3;
                end
            end
            default: if (restart) begin
                m_phase = 1;
                enter   = 1;
            end
        endcase
        if (enter) begin
            m_t    = 0;
            m_el   = 0;
            m_dly  = int'(cfg_delay);
            m_mode = cfg_mode;
        end
        e_stage  = (old_phase == 0) ? 2'(1 << old_passed) : 2'b00;
        e_cfg    = (old_phase == 1);
        e_done   = (old_phase == 2);
        e_fail   = (old_phase == 3);
        m_d2     = m_d1;
        m_d1     = cfg_done_in;
        m_pre_ff = prereq;
    endtask

    task automatic compare_model(input string name);
        logic [31:0] act;
        logic [31:0] exp;
        bit          e_msec;
        e_msec = (m_phase == 1) && ((m_t % TPM) == TPM - 1);
        act = {10'd0, wait_stage, wait_cfg, startup_done, startup_fail, msec_pulse, elapsed_msec};
        exp = {10'd0, e_stage, e_cfg, e_done, e_fail, e_msec, 16'(m_el)};
        check(name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_model("model");
    endtask

    typedef struct {
        logic [1:0] pq;
        logic [1:0] stage;
        logic       cfg;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s;
        int pulses;
        int done_at;
        int fail_at;
        int cfg_at;
        bit seen_fail;

        tbl[0] = '{2'b11, 2'b01, 1'b0};
        tbl[1] = '{2'b11, 2'b01, 1'b0};
        tbl[2] = '{2'b01, 2'b10, 1'b0};
        tbl[3] = '{2'b00, 2'b00, 1'b1};
        tbl[4] = '{2'b00, 2'b00, 1'b1};
        tbl[5] = '{2'b10, 2'b00, 1'b1};

        n_checks       = 0;
        n_pass         = 0;
        global_reset_n = 1'b0;
        prereq         = '0;
        cfg_delay      = 16'd3;
        cfg_mode       = 1'b0;
        cfg_done_in    = 1'b0;
        restart        = 1'b0;
        model_reset();

        #12;
        compare_model("reset_model");
        check("reset_stage", 32'(wait_stage), 32'd1);
        check("reset_flags", {29'd0, wait_cfg, startup_done, startup_fail}, 32'd0);
        #1 global_reset_n = 1'b1;

        // Bit 1 ready before bit 0: must hold on stage 0.
        prereq = 2'b10;
        repeat (50) step();
        check("t1_hold_stage", 32'(wait_stage), 32'd1);
        check("t1_hold_cfg", 32'(wait_cfg), 32'd0);

        for (int i = 0; i < 6; i++) begin
            prereq = tbl[i].pq;
            step();
            check($sformatf("t1_tbl%0d_stage", i), 32'(wait_stage), 32'(tbl[i].stage));
            check($sformatf("t1_tbl%0d_cfg", i), 32'(wait_cfg), 32'(tbl[i].cfg));
        end

        // Mode 0, 3 msec, entered at table row 2.
        s = 3; pulses = 0; done_at = -1;
        while (s < 60 && done_at < 0) begin
            step(); s++;
            if (msec_pulse) pulses++;
            if (startup_done) done_at = s;
        end
        check("t2_done_cycle", 32'(done_at), 32'd16);
        check("t2_pulses", 32'(pulses), 32'd3);
        check("t2_elapsed", 32'(elapsed_msec), 32'd3);
        repeat (10) step();
        check("t2_hold", {15'd0, startup_done, elapsed_msec}, {15'd0, 1'b1, 16'd3});

        // Mode 1, done arrives at cycle 12 of the wait.
        cfg_mode = 1'b1; cfg_delay = 16'd10; restart = 1'b1;
        step();
        restart = 1'b0;
        s = 0; done_at = -1;
        while (s < 40 && done_at < 0) begin
            if (s == 12) cfg_done_in = 1'b1;
            step(); s++;
            if (startup_done) done_at = s;
        end
        check("t3_done_cycle", 32'(done_at), 32'd16);
        check("t3_no_fail", 32'(startup_fail), 32'd0);
        check("t3_elapsed", 32'(elapsed_msec), 32'd3);

        // Mode 1, timeout then restart and late done.
        cfg_done_in = 1'b0;
        repeat (3) step();
        cfg_delay = 16'd4; restart = 1'b1;
        step();
        restart = 1'b0;
        check("t4_clr_elapsed", 32'(elapsed_msec), 32'd0);
        s = 0; fail_at = -1;
        while (s < 60 && fail_at < 0) begin
            step(); s++;
            if (startup_fail) fail_at = s;
        end
        check("t4_fail_cycle", 32'(fail_at), 32'd21);
        check("t4_fail_elapsed", 32'(elapsed_msec), 32'd4);
        check("t4_fail_no_done", 32'(startup_done), 32'd0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("t4_rearm_elapsed", 32'(elapsed_msec), 32'd0);
        step();
        check("t4_rearm_flags", {29'd0, wait_cfg, startup_done, startup_fail}, 32'd4);
        cfg_done_in = 1'b1;
        s = 1; done_at = -1;
        while (s < 30 && done_at < 0) begin
            step(); s++;
            if (startup_done) done_at = s;
        end
        check("t4_done_cycle", 32'(done_at), 32'd5);
        cfg_done_in = 1'b0;

        // Mode 0, zero delay: done straight after prereqs.
        #2 global_reset_n = 1'b0;
        model_reset();
        prereq = 2'b11; cfg_mode = 1'b0; cfg_delay = 16'd0;
        #1 compare_model("t5_reset");
        #2 global_reset_n = 1'b1;
        s = 0; cfg_at = -1; done_at = -1;
        while (s < 20 && done_at < 0) begin
            step(); s++;
            if (wait_cfg && cfg_at < 0) cfg_at = s;
            if (startup_done) done_at = s;
        end
        check("t5_cfg_cycle", 32'(cfg_at), 32'd4);
        check("t5_done_cycle", 32'(done_at), 32'd5);

        // Mode 1, zero delay: no timeout ever.
        cfg_mode = 1'b1; restart = 1'b1;
        step();
        restart = 1'b0;
        seen_fail = 0;
        repeat (1000) begin
            step();
            if (startup_fail) seen_fail = 1;
        end
        check("t5_never_fail", 32'(seen_fail), 32'd0);
        check("t5_still_wait", 32'(wait_cfg), 32'd1);
        check("t5_elapsed", 32'(elapsed_msec), 32'd200);

        // Asynchronous reset in the middle of the remote wait.
        #2 global_reset_n = 1'b0;
        #1;
        check("t6_async_vals", {22'd0, wait_stage, wait_cfg, startup_done, startup_fail, msec_pulse, elapsed_msec[3:0]},
              {22'd0, 2'b01, 8'd0});
        check("t6_async_elapsed", 32'(elapsed_msec), 32'd0);
        model_reset();
        #10 compare_model("t6_reset_hold");
        #1 global_reset_n = 1'b1;
        prereq = 2'b10;
        repeat (10) step();
        check("t6_restart_stage0", 32'(wait_stage), 32'd1);
        prereq = 2'b11;
        repeat (4) step();
        check("t6_reach_cfg", 32'(wait_cfg), 32'd1);
        prereq = 2'b00;
        repeat (5) step();
        check("t6_no_regress", {30'd0, wait_stage}, 32'd0);
        check("t6_still_cfg", 32'(wait_cfg), 32'd1);

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            prereq    = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            cfg_delay = 16'($urandom_range(0, 5));
            cfg_mode  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) cfg_done_in = ~cfg_done_in;
            restart   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 global_reset_n = 1'b0;
                model_reset();
                #1 compare_model("rand_reset");
                #2 global_reset_n = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
